// File: rtl/alarm_buzzer_pkg.sv
// alarm_buzzer_pkg: state encoding and default timing for the alarm buzzer driver
package alarm_buzzer_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, RING = 2'd1, SNOOZE = 2'd2, DONE = 2'd3} state_t;
    localparam int D_MS_DIV      = 50000;
    localparam int D_TONE_HALF   = 12500;
    localparam int D_BEEP_ON_MS  = 200;
    localparam int D_BEEP_OFF_MS = 200;
    localparam int D_RING_MS     = 60000;
    localparam int D_SNOOZE_MS   = 300000;
    localparam int D_MAX_SNOOZE  = 3;
endpackage

// File: rtl/btn_edge.sv
// btn_edge: rising-edge pulse from a debounced button level
module btn_edge (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    output logic pulse
);
    logic r_q;
    always_ff @(posedge clk) r_q <= reset ? 1'b0 : btn;
    assign pulse = btn & ~r_q;
endmodule

// File: rtl/alarm_buzzer_driver.sv
// alarm_buzzer_driver: beeping piezo tone driver with snooze, stop and ring timeout
module alarm_buzzer_driver
    import alarm_buzzer_pkg::*;
#(
    parameter int MS_DIV      = D_MS_DIV,
    parameter int TONE_HALF   = D_TONE_HALF,
    parameter int BEEP_ON_MS  = D_BEEP_ON_MS,
    parameter int BEEP_OFF_MS = D_BEEP_OFF_MS,
    parameter int RING_MS     = D_RING_MS,
    parameter int SNOOZE_MS   = D_SNOOZE_MS,
    parameter int MAX_SNOOZE  = D_MAX_SNOOZE
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       trig,
    input  logic       snooze_btn,
    input  logic       stop_btn,
    output logic       buzz,
    output logic       ringing,
    output logic       snoozing,
    output logic [2:0] snooze_cnt
);
    localparam int PW = $clog2(MS_DIV);
    localparam int TW = $clog2(TONE_HALF);
    localparam int BW = $clog2(BEEP_ON_MS + BEEP_OFF_MS);
    localparam int RW = $clog2(RING_MS);
    localparam int SW = $clog2(SNOOZE_MS);

    state_t        r_state, w_next;
    logic [PW-1:0] r_pre;
    logic [TW-1:0] r_tone;
    logic [BW-1:0] r_beep;
    logic [RW-1:0] r_ring_ms;
    logic [SW-1:0] r_snz_ms;
    logic          r_tone_q;
    logic          w_snz, w_stop, w_tick, w_chg, w_tone_end, w_beep_end;

    btn_edge u_snz  (.clk(clk), .reset(reset), .btn(snooze_btn), .pulse(w_snz));
    btn_edge u_stop (.clk(clk), .reset(reset), .btn(stop_btn),   .pulse(w_stop));

    assign w_tick     = r_pre == PW'(MS_DIV - 1);
    assign w_chg      = w_next != r_state;
    assign w_tone_end = r_tone == TW'(TONE_HALF - 1);
    assign w_beep_end = r_beep == BW'(BEEP_ON_MS + BEEP_OFF_MS - 1);

    always_comb begin
        w_next   = r_state;
        ringing  = r_state == RING;
        snoozing = r_state == SNOOZE;
        buzz     = (r_state == RING) & (r_beep < BW'(BEEP_ON_MS)) & r_tone_q;
        case (r_state)
            IDLE:   w_next = trig ? RING : IDLE;
            RING:   w_next = w_stop ? DONE
                           : (w_snz && snooze_cnt < 3'(MAX_SNOOZE)) ? SNOOZE
                           : (w_tick && r_ring_ms == RW'(RING_MS - 1)) ? DONE : RING;
            SNOOZE: w_next = w_stop ? DONE
                           : (w_tick && r_snz_ms == SW'(SNOOZE_MS - 1)) ? RING : SNOOZE;
            DONE:   w_next = trig ? DONE : IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= IDLE;
            r_pre      <= '0;
            r_tone     <= '0;
            r_tone_q   <= 1'b0;
            r_beep     <= '0;
            r_ring_ms  <= '0;
            r_snz_ms   <= '0;
            snooze_cnt <= '0;
        end else begin
            r_state   <= w_next;
            r_pre     <= (w_chg || w_tick) ? '0 : r_pre + 1'b1;
            r_ring_ms <= (w_chg || r_state != RING) ? '0 : r_ring_ms + RW'(w_tick);
            r_snz_ms  <= (w_chg || r_state != SNOOZE) ? '0 : r_snz_ms + SW'(w_tick);
            r_beep    <= (w_chg || r_state != RING || (w_tick && w_beep_end)) ? '0 : r_beep + BW'(w_tick);
            // every RING entry starts audible: tone high, counters from zero
            r_tone    <= (w_chg || r_state != RING || w_tone_end) ? '0 : r_tone + 1'b1;
            r_tone_q  <= w_chg ? (w_next == RING) : (r_state == RING) & (r_tone_q ^ w_tone_end);
            snooze_cnt <= (r_state == RING && w_next == SNOOZE) ? snooze_cnt + 3'd1
                        : (r_state == DONE && w_next == IDLE) ? 3'd0 : snooze_cnt;
        end
    end
endmodule

// File: tb/tb_alarm_buzzer_driver.sv
// tb_alarm_buzzer_driver: directed stimulus checked against a cycle-count model
module tb_alarm_buzzer_driver;
    localparam int MS_DIV = 4, TONE_HALF = 2, BEEP_ON_MS = 3, BEEP_OFF_MS = 2;
    localparam int RING_MS = 20, SNOOZE_MS = 10, MAX_SNOOZE = 2;
    localparam int RING_CYC = RING_MS * MS_DIV;
    localparam int SNZ_CYC  = SNOOZE_MS * MS_DIV;
    localparam int BEEP_PER = (BEEP_ON_MS + BEEP_OFF_MS) * MS_DIV;
    localparam int BEEP_ON  = BEEP_ON_MS * MS_DIV;

    logic       clk = 0, reset, trig, snooze_btn, stop_btn;
    logic       buzz, ringing, snoozing;
    logic [2:0] snooze_cnt;
    int         total = 0, bad = 0;
    bit         en = 0;

    alarm_buzzer_driver #(
        .MS_DIV(MS_DIV), .TONE_HALF(TONE_HALF), .BEEP_ON_MS(BEEP_ON_MS),
        .BEEP_OFF_MS(BEEP_OFF_MS), .RING_MS(RING_MS), .SNOOZE_MS(SNOOZE_MS),
        .MAX_SNOOZE(MAX_SNOOZE)
    ) dut (
        .clk(clk), .reset(reset), .trig(trig), .snooze_btn(snooze_btn), .stop_btn(stop_btn),
        .buzz(buzz), .ringing(ringing), .snoozing(snoozing), .snooze_cnt(snooze_cnt)
    );

    always #5 clk = ~clk;

    // mode: 0 idle, 1 ringing, 2 snoozing, 3 done; t counts cycles spent in the mode
    int m_mode = 0, m_t = 0, m_cnt = 0;
    bit m_sq = 0, m_tq = 0;
    always @(posedge clk) begin
        int nm;
        bit sp, tp;
        sp = snooze_btn & ~m_sq;
        tp = stop_btn & ~m_tq;
        if (reset) begin
            m_mode = 0; m_t = 0; m_cnt = 0; m_sq = 0; m_tq = 0;
        end else begin
            nm = m_mode;
            if (m_mode == 0 && trig) nm = 1;
            else if (m_mode == 1) begin
                if (tp) nm = 3;
                else if (sp && m_cnt < MAX_SNOOZE) begin nm = 2; m_cnt++; end
                else if (m_t == RING_CYC - 1) nm = 3;
            end else if (m_mode == 2) begin
                if (tp) nm = 3;
                else if (m_t == SNZ_CYC - 1) nm = 1;
            end else if (m_mode == 3 && !trig) begin nm = 0; m_cnt = 0; end
            m_t = (nm != m_mode) ? 0 : m_t + 1;
            m_mode = nm;
            m_sq = snooze_btn;
            m_tq = stop_btn;
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
        end
    endtask

    always @(negedge clk) if (en) begin
        chk("m_buzz", int'(buzz), int'(m_mode == 1 && (m_t % BEEP_PER) < BEEP_ON && (m_t % (2 * TONE_HALF)) < TONE_HALF));
        chk("m_ringing", int'(ringing), int'(m_mode == 1));
        chk("m_snoozing", int'(snoozing), int'(m_mode == 2));
        chk("m_cnt", int'(snooze_cnt), m_cnt);
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        logic [19:0] pat;
        pat = 20'b0000_0000_0011_0011_0011;
        reset = 1; trig = 0; snooze_btn = 0; stop_btn = 0;
        cyc(3);
        chk("rst_ringing", int'(ringing), 0);
        chk("rst_buzz", int'(buzz), 0);
        chk("rst_cnt", int'(snooze_cnt), 0);
        reset = 0; en = 1;
        cyc(2);
        trig = 1;
        for (int i = 0; i < 20; i++) begin
            cyc(1);
            if (i == 0) chk("ring_latency", int'(ringing), 1);
            chk("beep_pat", int'(buzz), int'(pat[i]));
        end
        cyc(60);
        chk("ring_last", int'(ringing), 1);
        cyc(1);
        chk("timeout", int'(ringing), 0);
        cyc(5);
        chk("no_rering", int'(ringing), 0);
        trig = 0; cyc(1);
        chk("rearm_cnt", int'(snooze_cnt), 0);
        trig = 1; cyc(1);
        chk("rearm_ring", int'(ringing), 1);
        cyc(4);
        snooze_btn = 1; cyc(1);
        chk("snz_state", int'(snoozing), 1);
        chk("snz_cnt1", int'(snooze_cnt), 1);
        chk("snz_quiet", int'(buzz), 0);
        snooze_btn = 0;
        cyc(39);
        chk("snz_last", int'(snoozing), 1);
        cyc(1);
        chk("snz_resume", int'(ringing), 1);
        chk("snz_resume_buzz", int'(buzz), 1);
        cyc(2);
        snooze_btn = 1; stop_btn = 1; cyc(1);
        chk("both_ringing", int'(ringing), 0);
        chk("both_snoozing", int'(snoozing), 0);
        chk("both_cnt", int'(snooze_cnt), 1);
        snooze_btn = 0; trig = 0; cyc(1);
        chk("done_clr_cnt", int'(snooze_cnt), 0);
        trig = 1; cyc(3);
        chk("held_stop", int'(ringing), 1);
        stop_btn = 0;
        snooze_btn = 1; cyc(1);
        chk("lim_cnt1", int'(snooze_cnt), 1);
        snooze_btn = 0; cyc(40);
        chk("lim_ring1", int'(ringing), 1);
        snooze_btn = 1; cyc(1);
        chk("lim_cnt2", int'(snooze_cnt), 2);
        snooze_btn = 0; cyc(40);
        chk("lim_ring2", int'(ringing), 1);
        snooze_btn = 1; cyc(1);
        chk("lim_ignored", int'(ringing), 1);
        chk("lim_cnt_hold", int'(snooze_cnt), 2);
        snooze_btn = 0; stop_btn = 1; cyc(1);
        chk("stop", int'(ringing), 0);
        stop_btn = 0; trig = 0; cyc(1);
        trig = 1; cyc(1);
        chk("ring_again", int'(ringing), 1);
        cyc(79);
        snooze_btn = 1; cyc(1);
        chk("snz_beats_timeout", int'(snoozing), 1);
        snooze_btn = 0; cyc(5);
        reset = 1; trig = 0; cyc(1);
        chk("mid_rst_snoozing", int'(snoozing), 0);
        chk("mid_rst_ringing", int'(ringing), 0);
        chk("mid_rst_cnt", int'(snooze_cnt), 0);
        reset = 0; trig = 1; cyc(1);
        chk("post_rst_ring", int'(ringing), 1);
        cyc(3);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not end, bad=%0d", bad);
        $fatal(1);
    end
endmodule

// File: doc/alarm_buzzer_driver.md
Name: alarm_buzzer_driver

Overview:
- Downstream of the alarm comparator. Consumes its single-bit match level (`trig`) and drives the physical piezo pin.
- Output is an audible square-wave tone, gated by an on/off beep pattern.
- Supports snooze (limited count), stop, and an automatic ring timeout.
- Re-arms only after the match level drops, so one alarm minute rings once.

Parameters:
- MS_DIV, 50000, clk cycles per 1 ms tick (50 MHz board clock)
- TONE_HALF, 12500, clk cycles per tone half-period (2 kHz tone)
- BEEP_ON_MS, 200, ms tone audible per beep
- BEEP_OFF_MS, 200, ms silent between beeps
- RING_MS, 60000, max ms in RING before automatic stop
- SNOOZE_MS, 300000, ms spent in SNOOZE before re-ringing
- MAX_SNOOZE, 3, number of snoozes allowed per alarm event

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- trig  in  1  alarm match level from the alarm comparator (high for the whole matching minute)
- snooze_btn  in  1  snooze button level (already debounced)
- stop_btn  in  1  stop button level (already debounced)
- buzz  out  1  piezo drive, square wave while audible
- ringing  out  1  high while in RING
- snoozing  out  1  high while in SNOOZE
- snooze_cnt  out  3  snoozes used in the current alarm event

Behaviour:
- One clock domain. Reset is synchronous and active-high, sampled on posedge clk, and overrides everything.
- Reset state:
  - state=IDLE; all counters 0; tone_q=0; snooze_cnt=0; button history regs=0.
  - buzz=0, ringing=0, snoozing=0.
- Buttons: rising-edge detect, pulse = btn & ~btn_q. Only pulses act; held levels are ignored.
- ms tick:
  - Prescaler counts 0..MS_DIV-1; tick asserts on the MS_DIV-1 cycle.
  - Prescaler clears on every state transition, so each state's timing starts aligned.
- States (2-bit) IDLE, RING, SNOOZE, DONE. Transitions are evaluated each cycle:
  - IDLE: trig=1 -> RING on the next edge, giving one cycle of latency from trig to ringing=1.
  - RING, evaluated in priority order:
    - stop pulse -> DONE.
    - snooze pulse with snooze_cnt<MAX_SNOOZE -> SNOOZE, and snooze_cnt+1.
    - snooze pulse with snooze_cnt==MAX_SNOOZE -> ignored, stay in RING.
    - ring ms count reaches RING_MS -> DONE. RING therefore lasts exactly RING_MS*MS_DIV cycles if undisturbed.
    - trig falling has no effect; ringing continues until stop or timeout.
  - SNOOZE:
    - stop pulse -> DONE.
    - snooze pulse -> ignored.
    - after SNOOZE_MS ms -> RING, with the ring timer and beep phase restarted.
  - DONE: trig=0 -> IDLE and snooze_cnt cleared to 0. While trig stays 1, remain in DONE, so there is no re-ring in the same minute.
- Simultaneous events:
  - stop and snooze pulses in the same cycle -> stop wins.
  - stop or snooze pulse in the same cycle as a timeout -> the button action wins.
- Beep pattern in RING:
  - beep_on=1 for the first BEEP_ON_MS ticks, then 0 for BEEP_OFF_MS ticks, repeating.
  - Restarts with beep_on=1 on every RING entry.
- Tone generator:
  - On RING entry: tone_q=1 and tone counter=0.
  - tone_q toggles every TONE_HALF cycles.
- Output decode:
  - buzz = (state==RING) & beep_on & tone_q. All terms are registered, so there are no glitches.
  - ringing and snoozing are decoded from the state register.
- Counter widths: each counter is sized by $clog2 of its parameter. No counter wraps; each clears on its terminal value or on a state change.

Decomposition:
- Package alarm_buzzer_pkg holds:
  - state encodings IDLE=0, RING=1, SNOOZE=2, DONE=3;
  - the default timing constants.
- One sub-module, btn_edge: a registered rising-edge pulse generator with sync reset, instantiated twice (snooze, stop).
- The prescaler, timers and FSM stay in the top module.

Test Plan:
Bench parameters: MS_DIV=4, TONE_HALF=2, BEEP_ON_MS=3, BEEP_OFF_MS=2, RING_MS=20, SNOOZE_MS=10, MAX_SNOOZE=2.
1. Ring and beep pattern: trig 0->1 at cycle 0 -> ringing=1 at cycle 1. buzz pattern is 1,1,0,0 repeating for 12 cycles, then buzz=0 for 8 cycles, and this repeats.
2. Timeout and re-arm: hold trig=1 with no buttons -> ringing falls exactly 80 cycles after rising, state DONE. trig held 1 gives no re-ring. Then trig=0 -> IDLE, snooze_cnt=0.
3. Snooze: snooze pulse in RING -> snoozing=1 next cycle, snooze_cnt=1, buzz=0. After 40 cycles -> ringing=1 with beep phase restarted, so buzz=1.
4. Snooze limit: two snoozes (cnt=2); a third snooze pulse -> stays ringing, cnt stays 2.
5. Simultaneous buttons: snooze_btn and stop_btn rise in the same cycle -> DONE, cnt unchanged. A held stop_btn produces only one pulse.
6. Reset mid-operation: reset=1 for one cycle during SNOOZE -> next cycle IDLE with all outputs 0 and cnt=0. trig=1 then re-rings after one cycle.
